// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, port select and grant pick.
// Default bus widths live here so the top and any wrappers agree.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUS_IP = 2'd1,
      BUS_DP = 2'd2,
      DONE   = 2'd3
   } arb_state_e;

   typedef enum logic {
      PORT_IP = 1'b0,
      PORT_DP = 1'b1
   } port_sel_e;

   // With both ports requesting, round-robin hands the grant to whoever did not win last.
   function automatic port_sel_e pick_grant(input logic      ip_req,
                                            input logic      dp_req,
                                            input logic      rr_en,
                                            input port_sel_e last);
      port_sel_e sel;
      if (ip_req && dp_req)
         sel = (rr_en && (last == PORT_DP)) ? PORT_IP : PORT_DP;
      else if (ip_req)
         sel = PORT_IP;
      else
         sel = PORT_DP;
      return sel;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Merges CPU fetch and data ports onto one Avalon-style master; one transfer at a time, strobe 1 cycle after grant, done pulse after completion.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests instead of fixed data-over-fetch priority.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ip_read,
   input  logic [ADDR_W-1:0]   ip_address,
   output logic [DATA_W-1:0]   ip_rdata,
   output logic                ip_done,
   input  logic                dp_read,
   input  logic                dp_write,
   input  logic [ADDR_W-1:0]   dp_address,
   input  logic [DATA_W-1:0]   dp_writedata,
   input  logic [DATA_W/8-1:0] dp_byteenable,
   output logic [DATA_W-1:0]   dp_rdata,
   output logic                dp_done,
   output logic [ADDR_W-1:0]   address,
   output logic                read,
   output logic                write,
   output logic [DATA_W-1:0]   writedata,
   output logic [DATA_W/8-1:0] byteenable,
   input  logic                waitrequest,
   input  logic [DATA_W-1:0]   readdata
);

   localparam int BE_W = DATA_W / 8;

   arb_state_e          r_state;
   arb_state_e          w_next_state;
   port_sel_e           r_owner;
   logic                r_is_write;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [BE_W-1:0]     r_be;
   logic [DATA_W-1:0]   r_ip_rdata;
   logic [DATA_W-1:0]   r_dp_rdata;

   logic                w_ip_req;
   logic                w_dp_req;
   logic                w_any_req;
   logic                w_grant_now;
   logic                w_xfer_done;
   port_sel_e           w_grant;
   port_sel_e           w_last;
   logic                w_read;
   logic                w_write;
   logic                w_ip_done;
   logic                w_dp_done;
   logic                w_unused;

   assign w_ip_req    = ip_read;
   assign w_dp_req    = dp_read | dp_write;
   assign w_any_req   = w_ip_req | w_dp_req;
   assign w_grant_now = (r_state == IDLE) && w_any_req;
   assign w_xfer_done = ((r_state == BUS_IP) || (r_state == BUS_DP)) && !waitrequest;
   assign w_unused    = ^{ip_address[1:0], dp_address[1:0]};

`ifdef ARB_ROUND_ROBIN_EN
   port_sel_e r_last_grant;

   always_ff @(posedge clk) begin
      if (rst)
         r_last_grant <= PORT_DP;
      else if (w_grant_now)
         r_last_grant <= w_grant;
   end

   assign w_last  = r_last_grant;
   assign w_grant = pick_grant(w_ip_req, w_dp_req, 1'b1, w_last);
`else
   assign w_last  = PORT_DP;
   assign w_grant = pick_grant(w_ip_req, w_dp_req, 1'b0, w_last);
`endif

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   // DONE always falls back to IDLE so a request still held during its done pulse is not re-granted.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_any_req)
               w_next_state = (w_grant == PORT_DP) ? BUS_DP : BUS_IP;
         end
         BUS_IP, BUS_DP: begin
            if (!waitrequest)
               w_next_state = DONE;
         end
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      w_read    = 1'b0;
      w_write   = 1'b0;
      w_ip_done = 1'b0;
      w_dp_done = 1'b0;
      case (r_state)
         BUS_IP: w_read = 1'b1;
         BUS_DP: begin
            w_read  = !r_is_write;
            w_write = r_is_write;
         end
         DONE: begin
            w_ip_done = (r_owner == PORT_IP);
            w_dp_done = (r_owner == PORT_DP);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner    <= PORT_DP;
         r_is_write <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_be       <= '0;
         r_ip_rdata <= '0;
         r_dp_rdata <= '0;
      end else begin
         if (w_grant_now) begin
            r_owner <= w_grant;
            if (w_grant == PORT_DP) begin
               r_addr     <= {dp_address[ADDR_W-1:2], 2'b00};
               r_wdata    <= dp_writedata;
               r_be       <= dp_byteenable;
               r_is_write <= dp_write;
            end else begin
               r_addr     <= {ip_address[ADDR_W-1:2], 2'b00};
               r_wdata    <= '0;
               r_be       <= '1;
               r_is_write <= 1'b0;
            end
         end
         if (w_xfer_done && !r_is_write) begin
            if (r_state == BUS_IP)
               r_ip_rdata <= readdata;
            else
               r_dp_rdata <= readdata;
         end
      end
   end

   assign address    = r_addr;
   assign writedata  = r_wdata;
   assign byteenable = r_be;
   assign read       = w_read;
   assign write      = w_write;
   assign ip_done    = w_ip_done;
   assign dp_done    = w_dp_done;
   assign ip_rdata   = r_ip_rdata;
   assign dp_rdata   = r_dp_rdata;

   // A simultaneous load and store is a core bug; the store wins.
   a_dp_rw_excl: assert property (@(posedge clk) disable iff (rst) !(dp_read && dp_write))
      else $error("dp_read and dp_write asserted together");

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ip_read;
   logic [31:0] ip_address;
   logic [31:0] ip_rdata;
   logic        ip_done;
   logic        dp_read;
   logic        dp_write;
   logic [31:0] dp_address;
   logic [31:0] dp_writedata;
   logic [3:0]  dp_byteenable;
   logic [31:0] dp_rdata;
   logic        dp_done;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        waitrequest;
   logic [31:0] readdata;

   always #5 clk = ~clk;

   mem_bus_arbiter dut (
      .clk(clk), .rst(rst),
      .ip_read(ip_read), .ip_address(ip_address), .ip_rdata(ip_rdata), .ip_done(ip_done),
      .dp_read(dp_read), .dp_write(dp_write), .dp_address(dp_address),
      .dp_writedata(dp_writedata), .dp_byteenable(dp_byteenable),
      .dp_rdata(dp_rdata), .dp_done(dp_done),
      .address(address), .read(read), .write(write), .writedata(writedata),
      .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
   );

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct {
      logic        ip_rd;
      logic [31:0] ip_addr;
      int          ip_wait;
      logic        dp_rd;
      logic        dp_wr;
      logic [31:0] dp_addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          dp_wait;
      logic        exp_dp_first;
      logic [31:0] exp_ip_addr;
      logic [31:0] exp_dp_addr;
   } vec_t;

   typedef struct {
      logic        is_dp;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          nwait;
      int          exp_done;
      logic [31:0] exp_rdata;
   } exp_t;

   localparam int NVEC = 7;
   vec_t vecs [NVEC];
   exp_t sb [$];
   int   n_vec  = 0;
   int   n_fail = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      exp_t ei, ed, first, second, f;
      int   cyc;
      int   strobes;
      ei = '{1'b0, 1'b0, v.exp_ip_addr, 32'h0, 4'hF, v.ip_wait, 0, mem_word(v.exp_ip_addr)};
      ed = '{1'b1, v.dp_wr, v.exp_dp_addr, v.wdata, v.be, v.dp_wait, 0, mem_word(v.exp_dp_addr)};
      if (v.ip_rd && (v.dp_rd || v.dp_wr)) begin
         first  = v.exp_dp_first ? ed : ei;
         second = v.exp_dp_first ? ei : ed;
         first.exp_done  = 2 + first.nwait;
         second.exp_done = first.exp_done + 3 + second.nwait;
         sb.push_back(first);
         sb.push_back(second);
      end else begin
         first = v.ip_rd ? ei : ed;
         first.exp_done = 2 + first.nwait;
         sb.push_back(first);
      end
      ip_read       = v.ip_rd;
      ip_address    = v.ip_addr;
      dp_read       = v.dp_rd;
      dp_write      = v.dp_wr;
      dp_address    = v.dp_addr;
      dp_writedata  = v.wdata;
      dp_byteenable = v.be;
      waitrequest   = 1'b0;
      readdata      = 32'hDEAD_BEEF;
      cyc     = 0;
      strobes = 0;
      while (sb.size() > 0 && cyc < 80) begin
         step();
         cyc++;
         waitrequest = 1'b0;
         readdata    = 32'hDEAD_BEEF;
         if (read || write) begin
            f = sb[0];
            strobes++;
            check("bus", {address, read, write, byteenable, f.wr ? writedata : 32'h0},
                         {f.addr, !f.wr, f.wr, f.be, f.wdata});
            if (ip_done || dp_done)
               check("strobe_in_done", {ip_done, dp_done}, 2'b00);
            if (strobes <= f.nwait)
               waitrequest = 1'b1;
            else
               readdata = mem_word(address);
         end
         if (ip_done || dp_done) begin
            f = sb.pop_front();
            check("done_port", {ip_done, dp_done}, f.is_dp ? 2'b01 : 2'b10);
            check("done_cycle", cyc, f.exp_done);
            check("strobe_cnt", strobes, f.nwait + 1);
            if (!f.wr)
               check("rdata", f.is_dp ? dp_rdata : ip_rdata, f.exp_rdata);
            if (f.is_dp) begin
               dp_read  = 1'b0;
               dp_write = 1'b0;
            end else begin
               ip_read = 1'b0;
            end
            strobes = 0;
         end
      end
      if (sb.size() > 0) begin
         check("txn_timeout", sb.size(), 0);
         sb.delete();
      end
      ip_read  = 1'b0;
      dp_read  = 1'b0;
      dp_write = 1'b0;
      step();
      check("idle_after", {read, write, ip_done, dp_done}, 4'b0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int done_cnt, dup, strb;

      vecs[0] = '{1'b1, 32'hBFC0_0000, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0,
                  1'b0, 32'hBFC0_0000, 32'h0};
      vecs[1] = '{1'b0, 32'h0, 0, 1'b0, 1'b1, 32'h0000_0AC2, 32'h1111_1111, 4'b1101, 3,
                  1'b1, 32'h0, 32'h0000_0AC0};
      vecs[2] = '{1'b1, 32'h0000_1004, 0, 1'b1, 1'b0, 32'h0000_2008, 32'h0, 4'hF, 0,
                  RR ? 1'b0 : 1'b1, 32'h0000_1004, 32'h0000_2008};
      vecs[3] = '{1'b1, 32'h0000_3001, 2, 1'b0, 1'b1, 32'h0000_4003, 32'hCAFE_F00D, 4'b0110, 1,
                  RR ? 1'b0 : 1'b1, 32'h0000_3000, 32'h0000_4000};
      vecs[4] = '{1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h0000_3FFE, 32'h0, 4'b0011, 1,
                  1'b1, 32'h0, 32'h0000_3FFC};
      vecs[5] = '{1'b1, 32'h0040_0007, 1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0,
                  1'b0, 32'h0040_0004, 32'h0};
      vecs[6] = '{1'b1, 32'h0000_0010, 0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 2,
                  1'b1, 32'h0000_0010, 32'h0000_0020};

      rst = 1'b1;
      ip_read = 1'b0; ip_address = '0;
      dp_read = 1'b0; dp_write = 1'b0; dp_address = '0;
      dp_writedata = '0; dp_byteenable = '0;
      waitrequest = 1'b0; readdata = '0;
      step();
      step();
      check("reset_state",
            {read, write, ip_done, dp_done, address, writedata, byteenable, ip_rdata, dp_rdata},
            {4'b0000, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0});
      rst = 1'b0;
      step();

      for (int i = 0; i < NVEC; i++)
         run_vec(vecs[i]);

      // Reset in the middle of a stalled data read, request held across it.
      dp_read = 1'b1; dp_address = 32'h0000_5000; dp_byteenable = 4'hF;
      waitrequest = 1'b1;
      step();
      check("rst_seq_strobe", {read, write, address}, {2'b10, 32'h0000_5000});
      step();
      rst = 1'b1;
      step();
      check("rst_seq_drop", {read, write, dp_done, ip_done}, 4'b0000);
      rst = 1'b0;
      waitrequest = 1'b0;
      step();
      check("rst_seq_regrant", {read, write, address}, {2'b10, 32'h0000_5000});
      readdata = mem_word(32'h0000_5000);
      step();
      readdata = 32'hDEAD_BEEF;
      check("rst_seq_done", {dp_done, read}, 2'b10);
      check("rst_seq_rdata", dp_rdata, mem_word(32'h0000_5000));
      dp_read = 1'b0;
      step();

      // Fetch request held continuously: one done per transaction, 3-cycle spacing.
      ip_read = 1'b1; ip_address = 32'h0000_0100;
      done_cnt = 0; dup = 0; strb = 0;
      for (int c = 1; c <= 8; c++) begin
         step();
         readdata = 32'hDEAD_BEEF;
         if (read) begin
            strb++;
            readdata = mem_word(address);
         end
         if (ip_done) begin
            done_cnt++;
            if (read || write) dup++;
         end
      end
      ip_read = 1'b0;
      check("held_done_cnt", done_cnt, 3);
      check("held_strobe_cnt", strb, 3);
      check("held_dup_strobe", dup, 0);
      check("held_rdata", ip_rdata, mem_word(32'h0000_0100));
      step();
      check("held_idle", {read, write, ip_done, dp_done}, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
